// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming multi-channel 3x3 convolution over raster pixels.
// Optional macro CONV_RELU_EN clamps negative results to zero.
module conv3x3_stream #(
    parameter int DW    = 23,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CH    = 2,
    parameter int WA_W  = $clog2(9 * CH),
    parameter int ACC_W = 2 * DW + WA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    input  logic             w_valid,
    input  logic [WA_W-1:0]  w_addr,
    input  logic [DW-1:0]    w_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*DW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last
);
    localparam int NW = 9 * CH;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic signed [DW-1:0] w_q [NW];
    logic signed [DW-1:0] w_d [NW];
    logic [CH*DW-1:0] lb0_mem [IMG_W];
    logic [CH*DW-1:0] lb1_mem [IMG_W];
    logic signed [DW-1:0] win_q [CH][3][2];
    logic signed [DW-1:0] win_d [CH][3][2];
    logic signed [DW-1:0] tap [CH][3][3];
    logic out_valid_q, out_valid_d;
    logic out_last_q, out_last_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic signed [ACC_W-1:0] acc, res;
    logic accept, produce, last_px;

    assign in_ready = (state_q == RUN) && (row_q < RW'(IMG_H))
                      && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign produce  = accept && (col_q >= CW'(2)) && (row_q >= RW'(2));
    assign last_px  = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));

    // Columns 0,1 come from the stored window; column 2 is the incoming one.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 3; r++) begin
                tap[c][r][0] = win_q[c][r][0];
                tap[c][r][1] = win_q[c][r][1];
            end
            tap[c][0][2] = lb1_mem[col_q][c*DW +: DW];
            tap[c][1][2] = lb0_mem[col_q][c*DW +: DW];
            tap[c][2][2] = in_data[c*DW +: DW];
        end
    end

    always_comb begin
        acc = '0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < 3; r++)
                for (int s = 0; s < 3; s++)
                    acc = acc + ACC_W'(w_q[c*9 + r*3 + s]) * ACC_W'(tap[c][r][s]);
`ifdef CONV_RELU_EN
        res = acc[ACC_W-1] ? '0 : acc;
`else
        res = acc;
`endif
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int c = 0; c < CH; c++)
                for (int r = 0; r < 3; r++) begin
                    win_d[c][r][0] = win_q[c][r][1];
                    win_d[c][r][1] = tap[c][r][2];
                end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        w_d         = w_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (w_valid && (w_addr < WA_W'(NW)))
                    w_d[w_addr] = w_data;
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
                if (out_valid_q && out_ready && out_last_q)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (produce) begin
            out_valid_d = 1'b1;
            out_last_d  = last_px;
            out_data_d  = res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < NW; i++) w_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            w_q         <= w_d;
        end
    end

    // Line buffers and window are don't-care after reset.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (accept) begin
            lb1_mem[col_q] <= lb0_mem[col_q];
            lb0_mem[col_q] <= in_data;
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_data_q;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed table-driven bench for conv3x3_stream on a 5x4, 2-channel frame.
module tb_conv3x3_stream;
    localparam int DW = 8;
    localparam int ACC_W = 21;
`ifdef CONV_RELU_EN
    localparam int NEG = 0;
`else
    localparam int NEG = -18;
`endif

    typedef struct {
        int w0;
        int w1;
        bit ctr;
        int mode;
        int p0;
        int p1;
        bit load;
        bit poke;
    } vec_t;

    logic clk = 0, rst = 1, start = 0, w_valid = 0;
    logic [4:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic in_valid = 0, out_ready = 0;
    logic [2*DW-1:0] in_data = '0;
    logic busy, frame_done, in_ready, out_valid, out_last;
    logic [ACC_W-1:0] out_data;

    vec_t vt [6];
    int exp_tab [6][6];
    int nvec = 0, nbad = 0;

    conv3x3_stream #(.DW(8), .IMG_W(5), .IMG_H(4), .CH(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .frame_done(frame_done), .w_valid(w_valid), .w_addr(w_addr),
        .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        nvec++;
        if (act != req) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic int wgt(input int vi, input int a);
        if (vt[vi].ctr) return (a == 4) ? vt[vi].w0 : 0;
        return (a < 9) ? vt[vi].w0 : vt[vi].w1;
    endfunction

    function automatic logic [2*DW-1:0] pix(input int vi, input int idx);
        int p0;
        p0 = (vt[vi].mode == 1) ? idx % 5 :
             (vt[vi].mode == 2) ? idx / 5 : vt[vi].p0;
        return {8'(vt[vi].p1), 8'(p0)};
    endfunction

    task automatic load_weights(input int vi);
        if (vt[vi].load) begin
            for (int a = 0; a < 18; a++) begin
                @(negedge clk);
                w_valid = 1;
                w_addr  = 5'(a);
                w_data  = 8'(wgt(vi, a));
                start   = (a == 17);
            end
        end else begin
            @(negedge clk);
            start = 1;
        end
    endtask

    task automatic stream(input int vi, input int stall);
        int px, got, cyc, held;
        bit seen_last, chk_lat;
        px = 0; got = 0; cyc = 0; held = 0;
        seen_last = 0; chk_lat = 0;
        while (!seen_last && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (chk_lat) begin
                chk("latency", int'(out_valid), 1);
                chk_lat = 0;
            end
            in_valid = (px < 20);
            in_data  = pix(vi, px);
            if (vt[vi].poke && (px == 3 || px == 10)) begin
                start = 1; w_valid = 1; w_addr = 5'd0; w_data = 8'd77;
            end else begin
                start = 0; w_valid = 0;
            end
            out_ready = !(out_valid && held < stall);
            #1;
            if (out_valid && !out_ready) begin
                held++;
                chk("stall_data", int'($signed(out_data)), exp_tab[vi][got]);
                chk("stall_in_ready", int'(in_ready), 0);
            end
            if (out_valid && out_ready) begin
                chk("result", int'($signed(out_data)), exp_tab[vi][got]);
                chk("last", int'(out_last), int'(got == 5));
                if (out_last) seen_last = 1;
                got++;
            end
            if (in_valid && in_ready) begin
                if (px == 12) chk_lat = 1;
                px++;
            end
        end
        if (!seen_last) chk("timeout", 0, 1);
        chk("result_count", got, 6);
        chk("pixel_count", px, 20);
        @(negedge clk);
        start = 0; w_valid = 0; in_valid = 0;
        chk("frame_done_hi", int'(frame_done), 1);
        chk("busy_done", int'(busy), 1);
        @(negedge clk);
        chk("frame_done_lo", int'(frame_done), 0);
        chk("busy_idle", int'(busy), 0);
        chk("out_valid_idle", int'(out_valid), 0);
    endtask

    initial begin
        int px, cyc;
        vt[0] = '{1, 0, 0, 0, 1, 0, 1, 0};
        vt[1] = '{1, 0, 1, 1, 0, 0, 1, 0};
        vt[2] = '{0, -1, 0, 0, 0, 2, 1, 0};
        vt[3] = '{1, 2, 0, 2, 0, 1, 1, 1};
        vt[4] = '{-128, -128, 0, 0, -128, -128, 1, 0};
        vt[5] = '{0, 0, 0, 0, 5, 3, 0, 0};
        exp_tab = '{'{9, 9, 9, 9, 9, 9},
                    '{1, 2, 3, 1, 2, 3},
                    '{NEG, NEG, NEG, NEG, NEG, NEG},
                    '{27, 27, 27, 36, 36, 36},
                    '{294912, 294912, 294912, 294912, 294912, 294912},
                    '{0, 0, 0, 0, 0, 0}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_frame_done", int'(frame_done), 0);

        for (int i = 0; i < 5; i++) begin
            load_weights(i);
            stream(i, 0);
        end

        load_weights(0);
        stream(0, 5);

        load_weights(0);
        px = 0; cyc = 0;
        while (px < 7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 0; w_valid = 0;
            in_valid = 1;
            in_data = pix(0, px);
            out_ready = 1;
            #1;
            if (in_valid && in_ready) px++;
        end
        chk("rst_seq_pixels", px, 7);
        @(negedge clk);
        rst = 1;
        in_valid = 0;
        @(posedge clk);
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        @(negedge clk);
        rst = 0;

        load_weights(5);
        stream(5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
